// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// regfile_wr_arbiter : round-robin arbiter for a register-bank write port,
//                      with a full-bank zero-fill sequence.        rev 1.0
// ============================================================================
`default_nettype none

module regfile_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int N        = 32,
  parameter int Bits     = 64,
  parameter int ZERO_REG = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*$clog2(N)-1:0]   req_ptr,
  input  logic [NREQ*Bits-1:0]        req_data,
  output logic [NREQ-1:0]             req_ready,
  input  logic                        clear_start,
  output logic                        busy,
  output logic                        clear_done,
  output logic                        wr_en,
  output logic [$clog2(N)-1:0]        ptr_wr,
  output logic [Bits-1:0]             data_wr
);

  localparam int PW = $clog2(N);
  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rr_q, rr_d;
  logic            wr_en_q, wr_en_d;
  logic [PW-1:0]   ptr_wr_q, ptr_wr_d;
  logic [Bits-1:0] data_wr_q, data_wr_d;
  logic            clear_done_q, clear_done_d;

  logic            grant_found;
  logic [RW-1:0]   grant_idx;
  logic            can_grant;
  logic            xfer;
  logic [PW-1:0]   grant_ptr;
  logic [Bits-1:0] grant_data;

  // Rotating priority search starting at rr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && req_valid[(int'(rr_q) + k) % NREQ]) begin
        grant_found = 1'b1;
        grant_idx   = RW'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  assign can_grant  = rst && (state_q == RUN) && !clear_start;
  assign xfer       = can_grant && grant_found;
  assign grant_ptr  = req_ptr[int'(grant_idx)*PW +: PW];
  assign grant_data = req_data[int'(grant_idx)*Bits +: Bits];
  assign req_ready  = xfer ? (NREQ'(1) << grant_idx) : '0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    wr_en_d      = 1'b0;
    ptr_wr_d     = ptr_wr_q;
    data_wr_d    = data_wr_q;
    clear_done_d = 1'b0;
    case (state_q)
      RUN: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (xfer) begin
          rr_d = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + RW'(1);
          // Register-0 writes still handshake but never reach the bank.
          if (!((ZERO_REG != 0) && (grant_ptr == '0))) begin
            wr_en_d   = 1'b1;
            ptr_wr_d  = grant_ptr;
            data_wr_d = grant_data;
          end
        end
      end
      CLEAR: begin
        // Track the clear write so ptr/data hold it once back in RUN.
        ptr_wr_d  = cnt_q;
        data_wr_d = '0;
        cnt_d     = cnt_q + PW'(1);
        if (cnt_q == PW'(N - 1)) begin
          state_d      = RUN;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      rr_q         <= '0;
      wr_en_q      <= 1'b0;
      ptr_wr_q     <= '0;
      data_wr_q    <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      wr_en_q      <= wr_en_d;
      ptr_wr_q     <= ptr_wr_d;
      data_wr_q    <= data_wr_d;
      clear_done_q <= clear_done_d;
    end
  end

  // Clear writes come straight from the counter; RUN writes from the register stage.
  assign busy       = (state_q == CLEAR);
  assign wr_en      = busy | wr_en_q;
  assign ptr_wr     = busy ? cnt_q : ptr_wr_q;
  assign data_wr    = busy ? '0 : data_wr_q;
  assign clear_done = clear_done_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
// tb_regfile_wr_arbiter : vector table + write scoreboard for the arbiter.
//                                                                  rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wr_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 32;
  localparam int BITS = 64;
  localparam int PW   = 5;

  localparam logic [19:0] C_PD = {5'd4, 5'd3, 5'd2, 5'd5};
  localparam logic [19:0] C_PZ = {5'd4, 5'd0, 5'd2, 5'd5};

  typedef struct {
    logic [3:0]  valid;
    logic [19:0] ptrs;
    logic        cs;
    logic [3:0]  exp_ready;
  } vec_t;

  typedef struct {
    logic            en;
    logic [PW-1:0]   ptr;
    logic [BITS-1:0] data;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*PW-1:0]     req_ptr;
  logic [NREQ*BITS-1:0]   req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   clear_start;
  logic                   busy;
  logic                   clear_done;
  logic                   wr_en;
  logic [PW-1:0]          ptr_wr;
  logic [BITS-1:0]        data_wr;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[17];

  regfile_wr_arbiter #(
    .NREQ(NREQ), .N(N), .Bits(BITS), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ptr(req_ptr), .req_data(req_data),
    .req_ready(req_ready),
    .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
    .wr_en(wr_en), .ptr_wr(ptr_wr), .data_wr(data_wr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NREQ*BITS-1:0] mkdata(input int k);
    logic [NREQ*BITS-1:0] d;
    for (int i = 0; i < NREQ; i++) d[i*BITS +: BITS] = (64'(k) << 8) | (64'hAA + 64'(i));
    return d;
  endfunction

  task automatic push_exp(input logic [3:0] rdy, input logic [19:0] ptrs, input logic [NREQ*BITS-1:0] d);
    exp_t e;
    e.en = 1'b0; e.ptr = '0; e.data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rdy[i]) begin
        e.ptr  = ptrs[i*PW +: PW];
        e.data = d[i*BITS +: BITS];
        e.en   = (e.ptr != 0);
      end
    end
    sb.push_back(e);
  endtask

  task automatic check_wr(input int k);
    exp_t e;
    if (sb.size() == 0) begin
      chk($sformatf("sb_empty[%0d]", k), 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("wr_en[%0d]", k), 64'(wr_en), 64'(e.en));
      if (e.en) begin
        chk($sformatf("ptr_wr[%0d]", k), 64'(ptr_wr), 64'(e.ptr));
        chk($sformatf("data_wr[%0d]", k), data_wr, e.data);
      end
    end
  endtask

  initial begin
    int done_cnt;
    logic [NREQ*BITS-1:0] d;

    vecs[0]  = '{4'b0001, C_PD, 1'b0, 4'b0001};
    vecs[1]  = '{4'b0000, C_PD, 1'b0, 4'b0000};
    vecs[2]  = '{4'b1000, C_PD, 1'b0, 4'b1000};
    vecs[3]  = '{4'b1111, C_PD, 1'b0, 4'b0001};
    vecs[4]  = '{4'b1111, C_PD, 1'b0, 4'b0010};
    vecs[5]  = '{4'b1111, C_PD, 1'b0, 4'b0100};
    vecs[6]  = '{4'b1111, C_PD, 1'b0, 4'b1000};
    vecs[7]  = '{4'b1111, C_PD, 1'b0, 4'b0001};
    vecs[8]  = '{4'b1111, C_PD, 1'b0, 4'b0010};
    vecs[9]  = '{4'b1111, C_PD, 1'b0, 4'b0100};
    vecs[10] = '{4'b1111, C_PD, 1'b0, 4'b1000};
    vecs[11] = '{4'b0100, C_PZ, 1'b0, 4'b0100};
    vecs[12] = '{4'b0101, C_PD, 1'b0, 4'b0001};
    vecs[13] = '{4'b0101, C_PD, 1'b0, 4'b0100};
    vecs[14] = '{4'b0011, C_PD, 1'b0, 4'b0001};
    vecs[15] = '{4'b0011, C_PD, 1'b0, 4'b0010};
    vecs[16] = '{4'b0000, C_PD, 1'b0, 4'b0000};

    rst = 1'b0; req_valid = 4'hF; req_ptr = C_PD; req_data = mkdata(0); clear_start = 1'b0;
    #12;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_ptr_wr", 64'(ptr_wr), 64'd0);
    chk("rst_data_wr", data_wr, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_clear_done", 64'(clear_done), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 17; k++) begin
      @(posedge clk); #1;
      if (k > 0) check_wr(k - 1);
      d = mkdata(k);
      req_valid = vecs[k].valid; req_ptr = vecs[k].ptrs; req_data = d; clear_start = vecs[k].cs;
      #1;
      chk($sformatf("ready[%0d]", k), 64'(req_ready), 64'(vecs[k].exp_ready));
      push_exp(vecs[k].exp_ready, vecs[k].ptrs, d);
    end
    @(posedge clk); #1;
    check_wr(16);

    // Clear requested together with a pending request from requester 1.
    d = mkdata(20);
    req_valid = 4'b0010; req_ptr = C_PD; req_data = d; clear_start = 1'b1;
    #1;
    chk("ready_at_clear_start", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    done_cnt = 0;
    for (int j = 0; j < N; j++) begin
      clear_start = (j == 5);
      #1;
      chk($sformatf("clr_busy[%0d]", j), 64'(busy), 64'd1);
      chk($sformatf("clr_ready[%0d]", j), 64'(req_ready), 64'd0);
      chk($sformatf("clr_wr_en[%0d]", j), 64'(wr_en), 64'd1);
      chk($sformatf("clr_ptr[%0d]", j), 64'(ptr_wr), 64'(j));
      chk($sformatf("clr_data[%0d]", j), data_wr, 64'd0);
      done_cnt += int'(clear_done);
      @(posedge clk); #1;
    end
    clear_start = 1'b0;
    #1;
    chk("clr_early_done", 64'(done_cnt), 64'd0);
    chk("done_pulse", 64'(clear_done), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_wr_en", 64'(wr_en), 64'd0);
    chk("done_ready", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    chk("after_done_pulse", 64'(clear_done), 64'd0);
    chk("pend_wr_en", 64'(wr_en), 64'd1);
    chk("pend_ptr", 64'(ptr_wr), 64'd2);
    chk("pend_data", data_wr, d[1*BITS +: BITS]);

    // Reset in the middle of a clear.
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
    end
    chk("mid_clear_ptr", 64'(ptr_wr), 64'd10);
    chk("mid_clear_busy", 64'(busy), 64'd1);
    d = mkdata(30);
    req_valid = 4'b1001; req_data = d;
    #1; rst = 1'b0; #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_wr_en", 64'(wr_en), 64'd0);
    chk("arst_ptr", 64'(ptr_wr), 64'd0);
    chk("arst_data", data_wr, 64'd0);
    chk("arst_done", 64'(clear_done), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk("arst_hold_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'b0001);
    chk("post_rst_done", 64'(clear_done), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    chk("post_rst_wr_en", 64'(wr_en), 64'd1);
    chk("post_rst_ptr", 64'(ptr_wr), 64'd5);
    chk("post_rst_data", data_wr, d[0 +: BITS]);
    chk("post_rst_no_done", 64'(clear_done), 64'd0);
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    #1;
    chk("restart_busy", 64'(busy), 64'd1);
    chk("restart_ptr", 64'(ptr_wr), 64'd0);
    done_cnt = 0;
    for (int j = 0; j < N + 2; j++) begin
      @(posedge clk); #1;
      done_cnt += int'(clear_done);
    end
    chk("restart_done_count", 64'(done_cnt), 64'd1);
    chk("restart_idle_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of write requesters sharing the bank write port.
REQ-002 The block SHALL have parameter N, default 32: number of registers in the bank.
REQ-003 The block SHALL have parameter Bits, default 64: register data width.
REQ-004 The block SHALL have parameter ZERO_REG, default 1: when 1, writes to register 0 are accepted and discarded.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have the following requester-side ports:
- req_valid  input  NREQ  per-requester write request.
- req_ptr  input  NREQ*$clog2(N)  per-requester destination pointer; requester i occupies slice i.
- req_data  input  NREQ*Bits  per-requester write data; requester i occupies slice i.
- req_ready  output  NREQ  per-requester accept; at most one bit set.
REQ-007 The block SHALL have the following clear-control ports:
- clear_start  input  1  request a zero-fill of the whole bank.
- busy  output  1  high while a clear sequence runs.
- clear_done  output  1  one-cycle pulse at clear completion.
REQ-008 The block SHALL have the following bank-side ports:
- wr_en  output  1  bank write enable.
- ptr_wr  output  $clog2(N)  bank write pointer.
- data_wr  output  Bits  bank write data.

Function
REQ-009 The block SHALL implement a two-state FSM, RUN and CLEAR, plus a $clog2(N)-bit clear counter and a $clog2(NREQ)-bit round-robin pointer rr.
REQ-010 The block SHALL select the grant in RUN with clear_start low: the first i with req_valid[i]=1, searching rr, rr+1, ... modulo NREQ.
REQ-011 req_ready SHALL be combinational; only the granted bit is 1, and all bits are 0 in CLEAR or when clear_start is 1.
REQ-012 A transfer SHALL occur when req_valid[i] and req_ready[i] are both 1 at a rising edge.
REQ-013 Requesters SHALL hold req_valid, req_ptr and req_data stable until the transfer; the block is not required to tolerate withdrawal.
REQ-014 The block SHALL register each write one cycle after the transfer edge: wr_en=1, ptr_wr=req_ptr[i], data_wr=req_data[i].
REQ-015 In any cycle without a transfer in RUN, the block SHALL drive wr_en=0; ptr_wr and data_wr hold their last values.
REQ-016 After each transfer, rr SHALL become (granted index + 1) mod NREQ; rr is unchanged when there is no transfer.
REQ-017 With ZERO_REG=1 and a transferred pointer of 0, the transfer SHALL complete (ready, rr advance) and the following cycle SHALL have wr_en=0.
REQ-018 The block SHALL sustain one write per cycle; back-to-back transfers from the same or different requesters are legal.
REQ-019 When clear_start=1 in RUN, the block SHALL take no transfer that cycle, and at the next edge set state to CLEAR and counter to 0.
REQ-020 In CLEAR, each cycle the block SHALL drive wr_en=1, ptr_wr=counter, data_wr=0, then increment the counter.
REQ-021 When the counter equals N-1 at an edge, the block SHALL return to RUN and pulse clear_done=1 for the following cycle, coincident with the first RUN cycle.
REQ-022 A full clear SHALL take exactly N write cycles, covering ptr 0..N-1 in order, including register 0 regardless of ZERO_REG.
REQ-023 busy SHALL be 1 exactly while state=CLEAR.
REQ-024 clear_start SHALL be ignored while in CLEAR.
REQ-025 rr SHALL NOT change during CLEAR.
REQ-026 Pending requests SHALL be served by the normal arbitration after CLEAR, starting from the preserved rr.
REQ-027 The block SHALL drop the final CLEAR write's wr_en in the cycle clear_done is high, unless a RUN transfer occurred in the prior cycle; no transfer is possible in the last CLEAR cycle.

Reset
REQ-028 While rst=0, the block SHALL force: state=RUN, rr=0, counter=0, wr_en=0, ptr_wr=0, data_wr=0, clear_done=0, busy=0, req_ready=0.
REQ-029 Assertion of rst mid-CLEAR SHALL abort the sequence immediately, with no clear_done pulse.
REQ-030 The first transfer after reset release SHALL be possible on the first rising edge with rst=1.

Verification
REQ-031 Single requester: req_valid=0001, req_ptr[0]=5, req_data[0]=0xAA -> ready[0]=1 the same cycle; next cycle wr_en=1, ptr_wr=5, data_wr=0xAA.
REQ-032 Round-robin: all four valid for 8 cycles, rr=0 -> grants 0,1,2,3,0,1,2,3, with wr_en high in 8 consecutive cycles.
REQ-033 Zero register: ZERO_REG=1, req_ptr=0 -> ready pulses and rr advances; wr_en stays 0 in the following cycle.
REQ-034 Clear: clear_start for 1 cycle, N=32 -> busy high for 32 cycles; ptr_wr 0..31 with data_wr=0; clear_done pulses once; req_ready=0 throughout.
REQ-035 Simultaneous: clear_start=1 with req_valid=0010 -> no transfer that cycle; requester 1 is served right after clear_done.
REQ-036 Reset mid-clear: rst=0 at counter=10 -> all outputs reach their reset values immediately; no clear_done pulse; the next clear_start restarts from ptr 0.
